yutorina_dmac: RTL and testbench

Single-channel word-copy DMA controller that occupies bus master 1 alongside the CPU on master 0. The CPU programs source, destination and count through a slave register port. The block then arbitrates for the bus and copies words with read-then-write bus cycles. On completion it raises a done flag and an optional interrupt.

---
 rtl/yutorina_dmac.sv | 200 ++++++++++++++++++++
 tb/tb_yutorina_dmac.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_dmac.sv
// Single-channel word-copy DMA controller acting as bus master 1.
// The CPU programs SRC/DST/CNT over the register port; the engine copies words with read-then-write cycles.
module yutorina_dmac #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_cs_,
  input  logic              s_as_,
  input  logic              s_rw,
  input  logic [1:0]        s_addr,
  input  logic [DATA_W-1:0] s_wr_data,
  output logic [DATA_W-1:0] s_rd_data,
  output logic              s_rdy_,
  output logic              m_req_,
  input  logic              m_grnt_,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_as_,
  output logic              m_rw,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              m_rdy_,
  output logic              irq
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    READ,
    WRITE,
    GAP
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [CNT_W-1:0]  cnt;
  logic              done;
  logic              ie;
  logic [DATA_W-1:0] data_buf;
  logic [DATA_W-1:0] rd_mux;

  logic access;
  logic reg_wr;
  logic reg_rd;
  logic busy;
  logic ctrl_wr;
  logic start_req;
  logic start_empty;
  logic word_done;
  logic last_word;

  // Upper write-data bits have no register behind them.
  logic unused_wr_hi;
  assign unused_wr_hi = ^s_wr_data[DATA_W-1:ADDR_W];

  assign access      = !s_cs_ && !s_as_;
  assign reg_wr      = access && !s_rw;
  assign reg_rd      = access && s_rw;
  assign busy        = (state != IDLE);
  assign ctrl_wr     = reg_wr && (s_addr == REG_CTRL);
  assign start_req   = ctrl_wr && s_wr_data[0] && !busy;
  assign start_empty = start_req && (cnt == '0);
  assign word_done   = (state == WRITE) && !m_rdy_;
  assign last_word   = word_done && (cnt == CNT_W'(1));

  assign irq       = done && ie;
  assign m_wr_data = data_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_req && (cnt != '0)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (!m_grnt_) begin
          state_next = READ;
        end
      end
      READ: begin
        if (!m_rdy_) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!m_rdy_) begin
          state_next = last_word ? IDLE : GAP;
        end
      end
      GAP: begin
        state_next = REQ;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req_ <= 1'b1;
      m_as_  <= 1'b1;
      m_rw   <= 1'b1;
      m_addr <= '0;
    end else begin
      m_req_ <= !((state_next == REQ) || (state_next == READ) || (state_next == WRITE));
      m_as_  <= !((state_next == READ) || (state_next == WRITE));
      m_rw   <= (state_next != WRITE);
      if (state_next == READ) begin
        m_addr <= src;
      end else if (state_next == WRITE) begin
        m_addr <= dst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_buf <= '0;
    end else if ((state == READ) && !m_rdy_) begin
      data_buf <= m_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src  <= '0;
      dst  <= '0;
      cnt  <= '0;
      done <= 1'b0;
      ie   <= 1'b0;
    end else begin
      if (reg_wr && !busy) begin
        case (s_addr)
          REG_SRC: src <= s_wr_data[ADDR_W-1:0];
          REG_DST: dst <= s_wr_data[ADDR_W-1:0];
          REG_CNT: cnt <= s_wr_data[CNT_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        ie <= s_wr_data[2];
        if (s_wr_data[1]) begin
          done <= 1'b0;
        end
      end
      if (word_done) begin
        src <= src + ADDR_W'(1);
        dst <= dst + ADDR_W'(1);
        cnt <= cnt - CNT_W'(1);
      end
      // Placed after the clear so a completion in the same cycle wins.
      if (start_empty || last_word) begin
        done <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_addr)
      REG_SRC: rd_mux[ADDR_W-1:0] = src;
      REG_DST: rd_mux[ADDR_W-1:0] = dst;
      REG_CNT: rd_mux[CNT_W-1:0]  = cnt;
      default: rd_mux[2:0]        = {ie, done, busy};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rdy_    <= 1'b1;
      s_rd_data <= '0;
    end else begin
      s_rdy_    <= !access;
      s_rd_data <= reg_rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_yutorina_dmac.sv
// Scoreboard bench for yutorina_dmac: register reads and bus cycles are queued when issued
// and checked by separate monitors when the DUT presents them.
module tb_yutorina_dmac;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_cs_ = 1'b1;
  logic              s_as_ = 1'b1;
  logic              s_rw = 1'b1;
  logic [1:0]        s_addr = 2'd0;
  logic [DATA_W-1:0] s_wr_data = '0;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_rdy_;
  logic              m_req_;
  logic              m_grnt_;
  logic [ADDR_W-1:0] m_addr;
  logic              m_as_;
  logic              m_rw;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rdy_;
  logic              irq;

  logic grant_hold = 1'b0;
  logic rdy_hold   = 1'b0;
  logic wr_hold    = 1'b0;

  int total = 0;
  int bad   = 0;

  bit              rq_is_rd[$];
  logic [31:0]     rq_data[$];
  string           rq_name[$];
  bit              bq_rw[$];
  logic [29:0]     bq_addr[$];
  logic [31:0]     bq_data[$];

  yutorina_dmac #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_cs_(s_cs_), .s_as_(s_as_), .s_rw(s_rw), .s_addr(s_addr),
    .s_wr_data(s_wr_data), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_),
    .m_req_(m_req_), .m_grnt_(m_grnt_), .m_addr(m_addr), .m_as_(m_as_),
    .m_rw(m_rw), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
    .m_rdy_(m_rdy_), .irq(irq)
  );

  always #5 clk = ~clk;

  // Source memory contents are a fixed function of the word address.
  function automatic logic [31:0] fmem(input logic [29:0] a);
    return {2'b10, a} ^ 32'h1234_5678;
  endfunction

  // Bus slave: immediate grant and zero-wait ready unless a hold is requested.
  assign m_grnt_   = m_req_ | grant_hold;
  assign m_rdy_    = m_as_ | rdy_hold | (wr_hold & ~m_rw);
  assign m_rd_data = fmem(m_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [1:0] addr, input logic [31:0] data,
                               input string name, input logic [31:0] exp_rd);
    s_cs_     = 1'b0;
    s_as_     = 1'b0;
    s_rw      = rw;
    s_addr    = addr;
    s_wr_data = data;
    rq_is_rd.push_back(rw);
    rq_data.push_back(exp_rd);
    rq_name.push_back(name);
    @(posedge clk); #1;
    s_cs_ = 1'b1;
    s_as_ = 1'b1;
    s_rw  = 1'b1;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, addr, data, "wr", 32'h0);
  endtask

  task automatic readReg(input logic [1:0] addr, input string name, input logic [31:0] exp_rd);
    applyStimulus(1'b1, addr, 32'h0, name, exp_rd);
  endtask

  task automatic expectRead(input logic [29:0] a);
    bq_rw.push_back(1'b1);
    bq_addr.push_back(a);
    bq_data.push_back(32'h0);
  endtask

  task automatic expectWrite(input logic [29:0] a, input logic [31:0] d);
    bq_rw.push_back(1'b0);
    bq_addr.push_back(a);
    bq_data.push_back(d);
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  // Register-port monitor: every s_rdy_ pulse consumes one issued access; reads are compared.
  always @(negedge clk) begin : reg_monitor
    bit          is_rd;
    logic [31:0] d;
    string       n;
    if (!rst && !s_rdy_) begin
      if (rq_is_rd.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL reg_unexpected: s_rdy_ pulse with no access outstanding, got 0 expected 1");
      end else begin
        is_rd = rq_is_rd.pop_front();
        d     = rq_data.pop_front();
        n     = rq_name.pop_front();
        if (is_rd) checkOutput(n, s_rd_data, d);
      end
    end
  end

  // Bus monitor: every completed bus cycle is matched against the expected transfer list.
  always @(negedge clk) begin : bus_monitor
    bit          rw;
    logic [29:0] a;
    logic [31:0] d;
    if (!rst && !m_as_ && !m_rdy_) begin
      if (bq_rw.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL bus_unexpected: rw=%0d addr=0x%08h expected no cycle", m_rw, m_addr);
      end else begin
        rw = bq_rw.pop_front();
        a  = bq_addr.pop_front();
        d  = bq_data.pop_front();
        checkOutput("bus_rw_addr", {1'b0, m_rw, m_addr}, {1'b0, rw, a});
        if (!rw) checkOutput("bus_wdata", m_wr_data, d);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin : main
    int cyc;
    bit req_seen;
    bit irq_seen;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_req_", {31'b0, m_req_}, 32'd1);
    checkOutput("rst_m_as_", {31'b0, m_as_}, 32'd1);
    checkOutput("rst_m_rw", {31'b0, m_rw}, 32'd1);
    checkOutput("rst_m_addr", {2'b0, m_addr}, 32'd0);
    checkOutput("rst_m_wr_data", m_wr_data, 32'd0);
    checkOutput("rst_s_rd_data", s_rd_data, 32'd0);
    checkOutput("rst_s_rdy_", {31'b0, s_rdy_}, 32'd1);
    checkOutput("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;
    nextCycle();
    readReg(2'd3, "rst_ctrl", 32'd0);

    // Three-word copy with interrupt enabled.
    writeReg(2'd0, 32'h100);
    writeReg(2'd1, 32'h200);
    writeReg(2'd2, 32'd3);
    for (int i = 0; i < 3; i++) begin
      expectRead(30'h100 + 30'(i));
      expectWrite(30'h200 + 30'(i), fmem(30'h100 + 30'(i)));
    end
    writeReg(2'd3, 32'h5);
    checkOutput("start_req_latency", {31'b0, m_req_}, 32'd0);
    cyc = 1;
    while (!irq && cyc < 40) begin
      nextCycle();
      cyc++;
    end
    checkOutput("irq_latency", cyc, 32'd12);
    readReg(2'd2, "copy_cnt", 32'd0);
    readReg(2'd3, "copy_ctrl", 32'h6);
    writeReg(2'd3, 32'h6);
    checkOutput("clear_irq", {31'b0, irq}, 32'd0);
    readReg(2'd3, "clear_ctrl", 32'h4);

    // Source address wraps from all-ones to zero; interrupt disabled.
    writeReg(2'd0, 32'h3FFF_FFFF);
    writeReg(2'd1, 32'h10);
    writeReg(2'd2, 32'd2);
    expectRead(30'h3FFF_FFFF);
    expectWrite(30'h10, fmem(30'h3FFF_FFFF));
    expectRead(30'h0);
    expectWrite(30'h11, fmem(30'h0));
    writeReg(2'd3, 32'h1);
    repeat (10) nextCycle();
    readReg(2'd3, "wrap_ctrl", 32'h2);
    readReg(2'd0, "wrap_src", 32'h1);
    readReg(2'd1, "wrap_dst", 32'h12);
    checkOutput("wrap_irq_off", {31'b0, irq}, 32'd0);

    // Zero-count start: no bus request, DONE the following cycle.
    writeReg(2'd3, 32'h2);
    writeReg(2'd2, 32'd0);
    writeReg(2'd3, 32'h1);
    checkOutput("cnt0_no_req", {31'b0, m_req_}, 32'd1);
    readReg(2'd3, "cnt0_ctrl", 32'h2);
    req_seen = 1'b0;
    irq_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!m_req_) req_seen = 1'b1;
      if (irq) irq_seen = 1'b1;
      nextCycle();
    end
    checkOutput("cnt0_req_quiet", {31'b0, req_seen}, 32'd0);
    checkOutput("cnt0_irq_quiet", {31'b0, irq_seen}, 32'd0);

    // Contention: grant withheld five cycles, then two wait states on the read.
    writeReg(2'd3, 32'h2);
    writeReg(2'd0, 32'h300);
    writeReg(2'd1, 32'h400);
    writeReg(2'd2, 32'd1);
    expectRead(30'h300);
    expectWrite(30'h400, fmem(30'h300));
    grant_hold = 1'b1;
    writeReg(2'd3, 32'h1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("cont_req_held", {31'b0, m_req_}, 32'd0);
      checkOutput("cont_no_as", {31'b0, m_as_}, 32'd1);
      nextCycle();
    end
    grant_hold = 1'b0;
    rdy_hold   = 1'b1;
    nextCycle();
    checkOutput("cont_wait1_as", {30'b0, m_as_, m_req_}, 32'd0);
    nextCycle();
    checkOutput("cont_wait2_as", {30'b0, m_as_, m_req_}, 32'd0);
    checkOutput("cont_wait2_addr", {1'b0, m_rw, m_addr}, {2'b01, 30'h300});
    nextCycle();
    rdy_hold = 1'b0;
    repeat (4) nextCycle();
    readReg(2'd0, "cont_src", 32'h301);
    readReg(2'd2, "cont_cnt", 32'd0);

    // Busy protection and live count during a four-word transfer.
    writeReg(2'd3, 32'h2);
    writeReg(2'd0, 32'h500);
    writeReg(2'd1, 32'h600);
    writeReg(2'd2, 32'd4);
    for (int i = 0; i < 4; i++) begin
      expectRead(30'h500 + 30'(i));
      expectWrite(30'h600 + 30'(i), fmem(30'h500 + 30'(i)));
    end
    writeReg(2'd3, 32'h5);
    writeReg(2'd0, 32'h55);
    nextCycle();
    nextCycle();
    readReg(2'd2, "busy_live_cnt", 32'd3);
    repeat (20) nextCycle();
    readReg(2'd0, "busy_src", 32'h504);
    checkOutput("busy_irq_set", {31'b0, irq}, 32'd1);

    // Reset in the middle of a stalled write cycle.
    writeReg(2'd0, 32'h700);
    writeReg(2'd1, 32'h800);
    writeReg(2'd2, 32'd2);
    expectRead(30'h700);
    wr_hold = 1'b1;
    writeReg(2'd3, 32'h5);
    nextCycle();
    nextCycle();
    checkOutput("mid_write_state", {30'b0, m_as_, m_rw}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_m_req_", {31'b0, m_req_}, 32'd1);
    checkOutput("abort_m_as_", {31'b0, m_as_}, 32'd1);
    checkOutput("abort_irq", {31'b0, irq}, 32'd0);
    nextCycle();
    rst     = 1'b0;
    wr_hold = 1'b0;
    nextCycle();
    readReg(2'd3, "post_rst_ctrl", 32'd0);
    readReg(2'd0, "post_rst_src", 32'd0);
    repeat (3) nextCycle();

    checkOutput("bus_queue_drained", bq_rw.size(), 32'd0);
    checkOutput("reg_queue_drained", rq_is_rd.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
